spi_arbiter: RTL

Shares one `SPI_Core` instance between N requesters, for example a sensor poller, a flash loader and a CPU bridge. Each requester asks for one 8-bit transaction with its own slave select, divisor and mode. The arbiter picks one requester, sequences the core's instruction writes (control, slave select, data) and waits for completion. It then returns the received byte to that requester and deselects the slave before serving the next one.

---
 rtl/spi_arbiter.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/spi_arbiter.sv
// spi_arbiter: shares one SPI core between N requesters.
//
// A winner is picked in IDLE and its fields are latched. The arbiter then
// issues the core's instruction writes (ctrl, slave select, start) on
// consecutive cycles and waits for the transfer to finish. It returns the
// received byte with a one-cycle ack and deselects the slave before serving
// the next requester.
//
// Configuration macro:
//   SPI_ARB_RR_EN  defined   -> round-robin grant, search starts after last winner
//                  undefined -> fixed priority, lowest index wins
//
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   req[N]                 level requests, held until ack
//   req_ss_n[N*S]          per-requester slave mask (slice i = [i*S +: S])
//   req_data[N*8]          per-requester transmit byte
//   req_dvsr[N*16]         per-requester SCLK divisor
//   req_cpol[N], req_cpha  per-requester SPI mode
//   ack[N]                 one-hot completion pulse
//   rsp_data[8]            received byte, valid from ack until the next ack
//   busy                   high from grant until back in IDLE
//   spi_write, spi_instr   core instruction write strobe / opcode
//   spi_ss_n, spi_data, spi_dvsr, spi_cpol, spi_cpha   core operands
//   spi_done, spi_rx       core idle flag / received byte
//
// State  | meaning
// IDLE   | waiting for a request while the core is idle
// CFG    | ctrl write (dvsr, cpol, cpha) on the outputs
// SEL    | slave-select write on the outputs
// START  | start write (tx byte) on the outputs
// WBUSY  | waiting for the core to report busy
// WDONE  | waiting for the core to finish; rx byte captured on exit
// RESP   | ack pulse and deselect write on the outputs
module spi_arbiter #(
    parameter int N = 4,
    parameter int S = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    req,
    input  logic [N*S-1:0]  req_ss_n,
    input  logic [N*8-1:0]  req_data,
    input  logic [N*16-1:0] req_dvsr,
    input  logic [N-1:0]    req_cpol,
    input  logic [N-1:0]    req_cpha,
    output logic [N-1:0]    ack,
    output logic [7:0]      rsp_data,
    output logic            busy,
    output logic            spi_write,
    output logic [1:0]      spi_instr,
    output logic [S-1:0]    spi_ss_n,
    output logic [7:0]      spi_data,
    output logic [15:0]     spi_dvsr,
    output logic            spi_cpol,
    output logic            spi_cpha,
    input  logic            spi_done,
    input  logic [7:0]      spi_rx
);

    localparam int GW = $clog2(N);

    typedef enum logic [2:0] {IDLE, CFG, SEL, START, WBUSY, WDONE, RESP} state_t;

    state_t state, state_next;

    logic [GW-1:0] g, win;
    logic [S-1:0]  lat_ss_n, win_ss_n;
    logic [7:0]    lat_data, win_data;
    logic [15:0]   win_dvsr;
    logic          win_cpol, win_cpha;
    logic          grant;

    logic [N-1:0]  ack_d;
    logic [7:0]    rsp_d;
    logic          busy_d, write_d, cpol_d, cpha_d;
    logic [1:0]    instr_d;
    logic [S-1:0]  ss_d;
    logic [7:0]    data_d;
    logic [15:0]   dvsr_d;

`ifdef SPI_ARB_RR_EN
    logic [GW-1:0] last_g, rr_start, win_lo, win_hi;
    logic          hit_hi;

    // Lowest requester at or above rr_start wins; otherwise wrap to the
    // lowest requester overall.
    always_comb begin
        rr_start = (last_g == GW'(N - 1)) ? '0 : last_g + GW'(1);
        win_lo   = '0;
        win_hi   = '0;
        hit_hi   = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_lo = GW'(i);
                if (GW'(i) >= rr_start) begin
                    win_hi = GW'(i);
                    hit_hi = 1'b1;
                end
            end
        end
        win = hit_hi ? win_hi : win_lo;
    end
`else
    always_comb begin
        win = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) win = GW'(i);
        end
    end
`endif

    always_comb begin
        win_ss_n = '1;
        win_data = '0;
        win_dvsr = '0;
        win_cpol = 1'b0;
        win_cpha = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (win == GW'(i)) begin
                win_ss_n = req_ss_n[i*S +: S];
                win_data = req_data[i*8 +: 8];
                win_dvsr = req_dvsr[i*16 +: 16];
                win_cpol = req_cpol[i];
                win_cpha = req_cpha[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Output values are computed for the state being entered, so that the
    // registered outputs line up with the state they belong to.
    always_comb begin
        state_next = state;
        grant      = 1'b0;
        ack_d      = '0;
        rsp_d      = rsp_data;
        write_d    = 1'b0;
        instr_d    = spi_instr;
        ss_d       = spi_ss_n;
        data_d     = spi_data;
        dvsr_d     = spi_dvsr;
        cpol_d     = spi_cpol;
        cpha_d     = spi_cpha;
        case (state)
            IDLE: begin
                if (|req && spi_done) begin
                    state_next = CFG;
                    grant      = 1'b1;
                    write_d    = 1'b1;
                    instr_d    = 2'b11;
                    dvsr_d     = win_dvsr;
                    cpol_d     = win_cpol;
                    cpha_d     = win_cpha;
                end
            end
            CFG: begin
                state_next = SEL;
                write_d    = 1'b1;
                instr_d    = 2'b01;
                ss_d       = lat_ss_n;
            end
            SEL: begin
                state_next = START;
                write_d    = 1'b1;
                instr_d    = 2'b10;
                data_d     = lat_data;
            end
            START: state_next = WBUSY;
            WBUSY: begin
                if (!spi_done) state_next = WDONE;
            end
            WDONE: begin
                if (spi_done) begin
                    state_next = RESP;
                    rsp_d      = spi_rx;
                    ack_d      = {{(N-1){1'b0}}, 1'b1} << g;
                    write_d    = 1'b1;
                    instr_d    = 2'b01;
                    ss_d       = '1;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        busy_d = (state_next != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            g         <= '0;
            lat_ss_n  <= '1;
            lat_data  <= '0;
            ack       <= '0;
            rsp_data  <= '0;
            busy      <= 1'b0;
            spi_write <= 1'b0;
            spi_instr <= 2'b00;
            spi_ss_n  <= '1;
            spi_data  <= '0;
            spi_dvsr  <= 16'h0200;
            spi_cpol  <= 1'b0;
            spi_cpha  <= 1'b0;
`ifdef SPI_ARB_RR_EN
            last_g    <= GW'(N - 1);
`endif
        end else begin
            if (grant) begin
                g        <= win;
                lat_ss_n <= win_ss_n;
                lat_data <= win_data;
`ifdef SPI_ARB_RR_EN
                last_g   <= win;
`endif
            end
            ack       <= ack_d;
            rsp_data  <= rsp_d;
            busy      <= busy_d;
            spi_write <= write_d;
            spi_instr <= instr_d;
            spi_ss_n  <= ss_d;
            spi_data  <= data_d;
            spi_dvsr  <= dvsr_d;
            spi_cpol  <= cpol_d;
            spi_cpha  <= cpha_d;
        end
    end

endmodule
